truth_table_sweeper: RTL and testbench

- Sequential stimulus/response engine for small combinational blocks.
- On a start request it drives every input vector of an N_IN-input DUT in ascending order.
- After a configurable settle time it samples the DUT's single output and assembles the observed truth table.
- It compares the table bit-by-bit against an expected table and reports pass/fail, mismatch count and the first failing vector.
- It is the synthesizable driver/checker end of the DUT's a/b/c -> y interface, replacing hand-written stimulus sequences.

---
 rtl/truth_table_sweeper.sv | 162 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// ---------------------------------------------------------------------------
// truth_table_sweeper
//
// Stimulus/response engine for a small combinational block with N_IN inputs
// and one output. On start it steps drv through 0 .. 2**N_IN-1. It holds each
// vector for SETTLE+1 cycles and samples dut_y on the last of those cycles.
// From the samples it builds the observed truth table tt and compares it
// bit-by-bit against EXPECTED.
//
// Ports
//   clk            : clock, rising edge active
//   rst_n          : asynchronous active-low reset
//   start          : sweep request, only looked at while idle
//   dut_y          : DUT output, combinational from drv
//   drv            : DUT input vector (drv[N_IN-1] is the MSB input "a")
//   busy           : sweep in progress
//   done           : one-cycle pulse when the last vector has been sampled
//   tt             : observed truth table, bit i = sampled y for drv == i
//   pass           : tt matched EXPECTED (valid from done onward)
//   mismatch_count : number of vectors whose sample differed from EXPECTED
//   fail_valid     : at least one mismatch seen in the current/last sweep
//   first_fail_idx : lowest mismatching vector (valid when fail_valid)
// ---------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int                 N_IN     = 3,
    parameter int                 SETTLE   = 2,
    parameter logic [2**N_IN-1:0] EXPECTED = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                dut_y,
    output logic [N_IN-1:0]     drv,
    output logic                busy,
    output logic                done,
    output logic [2**N_IN-1:0]  tt,
    output logic                pass,
    output logic [N_IN:0]       mismatch_count,
    output logic                fail_valid,
    output logic [N_IN-1:0]     first_fail_idx
);

    localparam logic [N_IN-1:0] LAST_IDX   = {N_IN{1'b1}};
    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [3:0]           cnt, cnt_nxt;
    logic [N_IN-1:0]      idx, idx_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic [2**N_IN-1:0]   tt_nxt;
    logic                 pass_nxt;
    logic [N_IN:0]        mc_nxt;
    logic                 fv_nxt;
    logic [N_IN-1:0]      ffi_nxt;

    // Sample-edge comparison and the count including the current sample;
    // the final pass decision needs the updated count, not the registered one.
    logic                 sample_miss;
    logic [N_IN:0]        mc_after;

    assign sample_miss = (dut_y != EXPECTED[idx]);
    assign mc_after    = mismatch_count + (N_IN+1)'(sample_miss);

    // The vector index doubles as the DUT drive; it is held through DONE and
    // IDLE until the next sweep clears it.
    assign drv = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            tt             <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            idx            <= idx_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            tt             <= tt_nxt;
            pass           <= pass_nxt;
            mismatch_count <= mc_nxt;
            fail_valid     <= fv_nxt;
            first_fail_idx <= ffi_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        tt_nxt    = tt;
        pass_nxt  = pass;
        mc_nxt    = mismatch_count;
        fv_nxt    = fail_valid;
        ffi_nxt   = first_fail_idx;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    cnt_nxt   = SETTLE_CNT;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    tt_nxt    = '0;
                    pass_nxt  = 1'b0;
                    mc_nxt    = '0;
                    fv_nxt    = 1'b0;
                    ffi_nxt   = '0;
                end
            end

            RUN: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    tt_nxt[idx] = dut_y;
                    mc_nxt      = mc_after;
                    // Only the first mismatch of a sweep is recorded.
                    if (sample_miss && !fail_valid) begin
                        fv_nxt  = 1'b1;
                        ffi_nxt = idx;
                    end
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (mc_after == '0);
                    end else begin
                        idx_nxt = idx + 1'b1;
                        cnt_nxt = SETTLE_CNT;
                    end
                end
            end

            // One-cycle stop so done is a single pulse and start is ignored.
            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: default parameters (SETTLE = 2)
    logic       start_a, y_a;
    logic [2:0] drv_a;
    logic       busy_a, done_a, pass_a, fv_a;
    logic [7:0] tt_a;
    logic [3:0] mc_a;
    logic [2:0] ffi_a;

    // Instance B: SETTLE = 0
    logic       start_b, y_b;
    logic [2:0] drv_b;
    logic       busy_b, done_b, pass_b, fv_b;
    logic [7:0] tt_b;
    logic [3:0] mc_b;
    logic [2:0] ffi_b;

    int mode_a, mode_b;
    int n_cmp  = 0;
    int n_fail = 0;

    truth_table_sweeper u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_y(y_a),
        .drv(drv_a), .busy(busy_a), .done(done_a), .tt(tt_a),
        .pass(pass_a), .mismatch_count(mc_a), .fail_valid(fv_a),
        .first_fail_idx(ffi_a)
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(0), .EXPECTED(8'hA5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_y(y_b),
        .drv(drv_b), .busy(busy_b), .done(done_b), .tt(tt_b),
        .pass(pass_b), .mismatch_count(mc_b), .fail_valid(fv_b),
        .first_fail_idx(ffi_b)
    );

    // Stand-in DUTs: 0 good (a XNOR c), 1 stuck-0, 2 stuck-1,
    // 3 good except y inverted on vector 6.
    function automatic logic dut_model(input int mode, input logic [2:0] v);
        logic good;
        good = ~(v[2] ^ v[0]);
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return (v == 3'd6) ? ~good : good;
            default: return good;
        endcase
    endfunction

    always_comb y_a = dut_model(mode_a, drv_a);
    always_comb y_b = dut_model(mode_b, drv_b);

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Issue a one-cycle start, then step one cycle at a time until done.
    // lat = edges from the start edge to the done edge (-1 on timeout).
    // drv_ok clears if drv or busy deviate from the expected stepping.
    task automatic run_sweep(input int sel, input int settle,
                             output int lat, output bit drv_ok);
        int         k;
        logic       d, b;
        logic [2:0] dv;
        drv_ok = 1'b1;
        lat    = -1;
        @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        k = 0;
        while (k < 200) begin
            d  = (sel == 0) ? done_a : done_b;
            b  = (sel == 0) ? busy_a : busy_b;
            dv = (sel == 0) ? drv_a  : drv_b;
            if (d) begin
                lat = k;
                if (b) drv_ok = 1'b0;
                break;
            end
            if (dv != 3'(k / (settle + 1)) || !b) drv_ok = 1'b0;
            @(negedge clk);
            k++;
        end
    endtask

    typedef struct {
        int         sel;
        int         mode;
        logic [7:0] tt;
        int         mc;
        logic       fv;
        int         ffi;
        logic       pass;
        int         lat;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   lat;
        bit   drv_ok;
        int   ndone;
        int   t[3];
        logic prev_busy;
        bit   clr_ok;
        int   k;

        vecs[0] = '{0, 0, 8'hA5, 0, 1'b0, 0, 1'b1, 24};
        vecs[1] = '{0, 1, 8'h00, 4, 1'b1, 0, 1'b0, 24};
        vecs[2] = '{0, 2, 8'hFF, 4, 1'b1, 1, 1'b0, 24};
        vecs[3] = '{1, 0, 8'hA5, 0, 1'b0, 0, 1'b1, 8};
        vecs[4] = '{1, 3, 8'hE5, 1, 1'b1, 6, 1'b0, 8};

        mode_a  = 0;
        mode_b  = 0;
        start_a = 1'b1;
        start_b = 1'b1;
        rst_n   = 1'b0;

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_busy", busy_a, 0);
            check("rst_outs", {drv_a, done_a, tt_a, pass_a, mc_a, fv_a, ffi_a}, 0);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        rst_n   = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_rst", {busy_a, done_a, drv_a, busy_b, drv_b}, 0);

        // Full sweeps from the vector table
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].sel == 0) mode_a = vecs[i].mode; else mode_b = vecs[i].mode;
            run_sweep(vecs[i].sel, (vecs[i].sel == 0) ? 2 : 0, lat, drv_ok);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_drv_step", i), drv_ok, 1);
            if (vecs[i].sel == 0) begin
                check($sformatf("v%0d_tt", i), tt_a, vecs[i].tt);
                check($sformatf("v%0d_mc", i), mc_a, vecs[i].mc);
                check($sformatf("v%0d_fv", i), fv_a, vecs[i].fv);
                check($sformatf("v%0d_ffi", i), ffi_a, vecs[i].ffi);
                check($sformatf("v%0d_pass", i), pass_a, vecs[i].pass);
                @(negedge clk);
                check($sformatf("v%0d_done_1cyc", i), done_a, 0);
                check($sformatf("v%0d_drv_hold", i), drv_a, 7);
            end else begin
                check($sformatf("v%0d_tt", i), tt_b, vecs[i].tt);
                check($sformatf("v%0d_mc", i), mc_b, vecs[i].mc);
                check($sformatf("v%0d_fv", i), fv_b, vecs[i].fv);
                check($sformatf("v%0d_ffi", i), ffi_b, vecs[i].ffi);
                check($sformatf("v%0d_pass", i), pass_b, vecs[i].pass);
                @(negedge clk);
                check($sformatf("v%0d_done_1cyc", i), done_b, 0);
                check($sformatf("v%0d_drv_hold", i), drv_b, 7);
            end
            @(negedge clk);
        end

        // Start pulses while busy are ignored
        mode_a  = 0;
        ndone   = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_a) ndone++;
            start_a = (c == 5 || c == 10);
        end
        start_a = 1'b0;
        check("single_done", ndone, 1);

        // Start held high: back-to-back sweeps, results cleared at each start
        mode_a    = 1;
        ndone     = 0;
        clr_ok    = 1'b1;
        prev_busy = busy_a;
        start_a   = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (busy_a && !prev_busy && (mc_a != 0 || fv_a || tt_a != 0)) clr_ok = 1'b0;
            if (done_a) begin
                if (ndone < 3) t[ndone] = c;
                ndone++;
            end
            prev_busy = busy_a;
        end
        start_a = 1'b0;
        check("held_done_count", ndone, 3);
        check("held_clear", clr_ok, 1);
        if (ndone >= 3) begin
            check("period_1", t[1] - t[0], 26);
            check("period_2", t[2] - t[1], 26);
        end
        k = 0;
        while ((busy_a || done_a) && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", k < 60, 1);
        @(negedge clk);

        // Mid-sweep asynchronous reset
        mode_a  = 0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while (drv_a != 3'd4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("reach_drv4", drv_a, 4);
        check("tt_partial", tt_a, 8'h05);
        #2 rst_n = 1'b0;
        #1;
        check("async_clr", {drv_a, busy_a, tt_a, mc_a, fv_a, ffi_a, pass_a}, 0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done_a || busy_a) ndone++;
        end
        check("no_done_after_rst", ndone, 0);
        run_sweep(0, 2, lat, drv_ok);
        check("post_rst_latency", lat, 24);
        check("post_rst_tt", tt_a, 8'hA5);
        check("post_rst_pass", pass_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "timeout");
    end

endmodule
